timer_bus: RTL
==============

# timer_bus

Memory-mapped 32-bit down-counting timer on the SoC data bus, decoded by the top level at `ram_addr[31:28]==4'hc` with the same `ce`/`we`/`addr`/`din`/`dout` handshake as `rxtx_bus` and `gpio_bus`. Its `irq` output drives the CPU core's `irq` input, which is currently tied low. Firmware gets a periodic or one-shot interrupt source without polling the UART.

## Interface
- `PRESCALE`, default 25: clk cycles per timer tick; must be ≥1. Default gives a 1 µs tick at 25 MHz.
- `clk` in 1: system clock (PLL output).
- `rst` in 1: reset, asynchronous, active-high.
- `ce` in 1: chip enable; top-level region decode qualified by `ram_cen`.
- `we` in 1: write strobe, qualified by `ce`.
- `addr` in 4: byte address; bits [3:2] select the register, bits [1:0] are ignored.
- `din` in 32: write data.
- `dout` out 32: registered read data.
- `irq` out 1: level interrupt to the CPU.

## Operation
Register map:
- 0x0 CTRL, R/W.
  - bit0 EN: counting enabled.
  - bit1 AUTO: auto-reload on expiry.
  - bit2 IE: interrupt enable.
  - Bits [31:3] read 0.
- 0x4 LOAD, R/W: 32-bit reload value.
- 0x8 COUNT, R/W: current count. A write sets the count directly.
- 0xC STATUS, R/W1C: bit0 EXP, sticky expiry flag. Writing 1 clears it. Writing 0 has no effect. Bits [31:1] read 0.

Tick generation:
- The prescaler counts 0..PRESCALE-1 while EN=1.
- A tick is asserted for one clk when the prescaler equals PRESCALE-1; the prescaler then wraps to 0.
- The prescaler is held at 0 while EN=0.
- Any CTRL write with din[0]=1 restarts the prescaler at 0.

Count behaviour on each tick:
- COUNT≠0: COUNT ← COUNT−1.
- COUNT=0 (expiry):
  - EXP ← 1.
  - If AUTO=1: COUNT ← LOAD.
  - If AUTO=0: EN ← 0 and COUNT stays 0.
- Auto-reload period is (LOAD+1)·PRESCALE clk cycles.
- LOAD=0 with AUTO=1 expires on every tick.

Interrupt and reset:
- `irq` = EXP & IE. Both are flop outputs, so `irq` is glitch-free.
- On reset: CTRL, LOAD, COUNT, EXP, prescaler, `dout` and `irq` are all 0.

## Timing
- **Writes:** take effect on the clk edge where ce&we=1.
- **Reads:** when ce&~we=1, `dout` loads the addressed register on that edge and is valid the following cycle. This matches the top level's delayed `mod_sel_d` mux. Otherwise `dout` holds its value.
- **Read data age:** a read of COUNT returns the value before that edge's update.

Simultaneous events:
- COUNT write + tick: the written value wins; no decrement that cycle.
- CTRL write clearing EN + tick: the write wins; no count change and no expiry.
- W1C of EXP + expiry in the same cycle: set wins, so EXP=1.
- LOAD write + auto-reload expiry in the same cycle: COUNT takes the old LOAD; the new LOAD is used from the next reload.

Other rules:
- Reset asserted mid-count returns every register to 0 immediately, with no pending expiry.

## Configuration
- `TIMER_BUS_PRESCALER_EN`:
  - Defined: the prescaler is built as described, and ticks occur every PRESCALE clk cycles.
  - Undefined: there is no prescaler; tick = EN every clk cycle, and `PRESCALE` is ignored. Register map and all other behaviour are unchanged.

## Structure
- Package `timer_bus_pkg` contains:
  - register offsets: `TMR_CTRL`=4'h0, `TMR_LOAD`=4'h4, `TMR_COUNT`=4'h8, `TMR_STATUS`=4'hC;
  - CTRL bit indices: `TMR_EN_BIT`=0, `TMR_AUTO_BIT`=1, `TMR_IE_BIT`=2.
- One sub-module, `timer_prescaler`:
  - parameter PRESCALE;
  - inputs clk, rst, en, restart;
  - output tick.
- `timer_prescaler` is instantiated only under `TIMER_BUS_PRESCALER_EN`.

## Test plan
Unless stated otherwise, PRESCALE=4 with the macro defined.

1. **Reset state:** assert rst, then read all four registers → every read returns 0x0000_0000 and `irq`=0.
2. **One-shot:** write LOAD=3, COUNT=3, CTRL=0x5 →
   - EXP=1 and `irq`=1 exactly 16 clk after the CTRL write;
   - CTRL reads 0x4 (EN cleared);
   - COUNT reads 0.
3. **Auto-reload:** LOAD=2, COUNT=2, CTRL=0x7 →
   - EXP sets every 12 clk;
   - after each expiry, COUNT reads 2 then 1 then 0;
   - W1C to STATUS drops `irq` the next cycle.
4. **Clear/expiry collision:** write STATUS=0x1 on the same edge as an expiry → EXP remains 1 and `irq` stays high.
5. **COUNT write/tick collision:** write COUNT=0x100 on a tick edge → a read the cycle after returns 0x100, not 0xFF.
6. **Macro undefined:** LOAD=1, COUNT=1, CTRL=0x3 → EXP sets every 2 clk.

Source files
------------

// File: rtl/timer_bus_pkg.sv
// Shared register offsets and CTRL bit positions for the memory-mapped timer.
package timer_bus_pkg;

  localparam logic [3:0] TMR_CTRL   = 4'h0;
  localparam logic [3:0] TMR_LOAD   = 4'h4;
  localparam logic [3:0] TMR_COUNT  = 4'h8;
  localparam logic [3:0] TMR_STATUS = 4'hC;

  localparam int TMR_EN_BIT   = 0;
  localparam int TMR_AUTO_BIT = 1;
  localparam int TMR_IE_BIT   = 2;
  localparam int TMR_CTRL_W   = 3;

endpackage

// File: rtl/timer_prescaler.sv
// Clock divider producing a one-cycle tick every PRESCALE clk while enabled.
// Only built when TIMER_BUS_PRESCALER_EN is defined.
`ifdef TIMER_BUS_PRESCALER_EN
module timer_prescaler #(
  parameter int PRESCALE = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = en & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    // Disabled or restarted parks at 0 so the first tick is a full period away.
    if (!en || restart || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule
`endif

// File: rtl/timer_bus.sv
// 32-bit down-counting bus timer with sticky expiry flag and level irq.
// Define TIMER_BUS_PRESCALER_EN to tick every PRESCALE clk; otherwise it ticks every clk.
module timer_bus
  import timer_bus_pkg::*;
#(
  parameter int PRESCALE = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  logic [TMR_CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]           load_q, load_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           dout_q, dout_d;
  logic                  exp_q, exp_d;

  logic [3:0] reg_off;
  logic       addr_unused;
  logic       wr_en, rd_en;
  logic       ctrl_wr, load_wr, count_wr, status_wr;
  logic       tick, tick_take, expire;

  assign reg_off     = {addr[3:2], 2'b00};
  assign addr_unused = ^addr[1:0];
  assign wr_en       = ce & we;
  assign rd_en       = ce & ~we;
  assign ctrl_wr     = wr_en & (reg_off == TMR_CTRL);
  assign load_wr     = wr_en & (reg_off == TMR_LOAD);
  assign count_wr    = wr_en & (reg_off == TMR_COUNT);
  assign status_wr   = wr_en & (reg_off == TMR_STATUS);

`ifdef TIMER_BUS_PRESCALER_EN
  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en      (ctrl_q[TMR_EN_BIT]),
    .restart (ctrl_wr & din[TMR_EN_BIT]),
    .tick    (tick)
  );
`else
  logic prescale_unused;
  assign prescale_unused = ^PRESCALE;
  assign tick = ctrl_q[TMR_EN_BIT];
`endif

  // A COUNT write, or a CTRL write that disables the timer, swallows a coincident tick.
  assign tick_take = tick & ~count_wr & ~(ctrl_wr & ~din[TMR_EN_BIT]);
  assign expire    = tick_take & (count_q == 32'd0);

  always_comb begin
    ctrl_d  = ctrl_q;
    load_d  = load_q;
    count_d = count_q;
    exp_d   = exp_q;
    dout_d  = dout_q;

    if (tick_take) begin
      if (!expire)                    count_d = count_q - 32'd1;
      else if (ctrl_q[TMR_AUTO_BIT])  count_d = load_q;
      else                            ctrl_d[TMR_EN_BIT] = 1'b0;
    end

    if (ctrl_wr)  ctrl_d  = din[TMR_CTRL_W-1:0];
    if (load_wr)  load_d  = din;
    if (count_wr) count_d = din;

    // Expiry is applied after the W1C so a same-cycle set is never lost.
    if (status_wr && din[0]) exp_d = 1'b0;
    if (expire)              exp_d = 1'b1;

    if (rd_en) begin
      case (reg_off)
        TMR_CTRL:  dout_d = {29'd0, ctrl_q};
        TMR_LOAD:  dout_d = load_q;
        TMR_COUNT: dout_d = count_q;
        default:   dout_d = {31'd0, exp_q};
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= '0;
      load_q  <= '0;
      count_q <= '0;
      exp_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      load_q  <= load_d;
      count_q <= count_d;
      exp_q   <= exp_d;
      dout_q  <= dout_d;
    end
  end

  assign dout = dout_q;
  assign irq  = exp_q & ctrl_q[TMR_IE_BIT];

endmodule
